chorus_lfo: RTL and testbench



---
 rtl/chorus_pkg.sv | 44 ++++
 rtl/chorus_lfo_tri.sv | 50 +++++
 rtl/chorus_lfo.sv | 85 ++++++++
 tb/tb_chorus_lfo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/chorus_pkg.sv
// Shared widths, buffer geometry and small arithmetic helpers for the chorus path.
// Used by chorus_lfo and chorus_lfo_tri.
package chorus_pkg;

   localparam int SAMPLE_W           = 16;
   localparam int PHASE_W            = 24;
   localparam int TRI_W              = 15;
   localparam int BUF_SIZE           = 44100;
   localparam int MAX_DELAY          = BUF_SIZE - 1;
   localparam int DEFAULT_BASE_DELAY = 441;

   localparam int PROD_W = TRI_W + SAMPLE_W;
   localparam int SUM_W  = SAMPLE_W + 1;

   typedef struct packed {
      logic                valid;
      logic [SAMPLE_W-1:0] scaled;
   } stage2_t;

   // The offset sum carries one extra bit so an overflowing target still clamps correctly.
   function automatic logic [SAMPLE_W-1:0] clamp_delay(
      input logic [SUM_W-1:0]    sum,
      input logic [SAMPLE_W-1:0] ceiling
   );
      if (sum > {1'b0, ceiling}) begin
         return ceiling;
      end
      return sum[SAMPLE_W-1:0];
   endfunction

   function automatic logic [SAMPLE_W-1:0] slew_toward(
      input logic [SAMPLE_W-1:0] target,
      input logic [SAMPLE_W-1:0] current
   );
      if (target > current) begin
         return current + 16'd1;
      end
      if (target < current) begin
         return current - 16'd1;
      end
      return current;
   endfunction

endpackage

// File: rtl/chorus_lfo_tri.sv
// Phase accumulator with hold, folded into a 15-bit triangle.
// tri_o reflects the phase after the most recent tick; valid_o marks the cycle it is fresh.
module chorus_lfo_tri
   import chorus_pkg::*;
#(
   parameter int PHASE_W = chorus_pkg::PHASE_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick_i,
   input  logic                hold_i,
   input  logic [SAMPLE_W-1:0] rate_i,
   output logic [TRI_W-1:0]    tri_o,
   output logic                valid_o
);

   logic [PHASE_W-1:0] phase_q;
   logic [PHASE_W-1:0] phase_d;
   logic               valid_q;
   logic               valid_d;

   always_comb begin
      phase_d = phase_q;
      valid_d = tick_i;
      if (tick_i && !hold_i) begin
         phase_d = phase_q + PHASE_W'(rate_i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q <= '0;
         valid_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         valid_q <= valid_d;
      end
   end

   // Top bit selects the falling half; inverting the next TRI_W bits mirrors it.
   always_comb begin
      tri_o = phase_q[PHASE_W-2 -: TRI_W];
      if (phase_q[PHASE_W-1]) begin
         tri_o = ~phase_q[PHASE_W-2 -: TRI_W];
      end
   end

   assign valid_o = valid_q;

endmodule

// File: rtl/chorus_lfo.sv
// Chorus LFO: triangle scaled by depth, offset by BASE_DELAY, clamped, strobed 3 cycles after each tick.
// Define CHORUS_LFO_SMOOTH_EN to slew the output by at most one sample per pulse.
module chorus_lfo
   import chorus_pkg::*;
#(
   parameter int BASE_DELAY = chorus_pkg::DEFAULT_BASE_DELAY,
   parameter int MAX_DELAY  = chorus_pkg::MAX_DELAY,
   parameter int PHASE_W    = chorus_pkg::PHASE_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sampleTick,
   input  logic                hold,
   input  logic [SAMPLE_W-1:0] rate,
   input  logic [SAMPLE_W-1:0] depth,
   output logic [SAMPLE_W-1:0] delay,
   output logic                bufEnable,
   output logic                delayValid
);

   localparam logic [SAMPLE_W-1:0] BASE_VAL = SAMPLE_W'(BASE_DELAY);
   localparam logic [SAMPLE_W-1:0] MAX_VAL  = SAMPLE_W'(MAX_DELAY);

   logic [TRI_W-1:0]    tri_val;
   logic                tri_valid;

   stage2_t             stage2_q;
   stage2_t             stage2_d;
   logic                valid3_q;
   logic                valid3_d;
   logic [SAMPLE_W-1:0] delay_q;
   logic [SAMPLE_W-1:0] delay_d;
   logic [SAMPLE_W-1:0] target;

   chorus_lfo_tri #(
      .PHASE_W(PHASE_W)
   ) u_tri (
      .clk    (clk),
      .reset  (reset),
      .tick_i (sampleTick),
      .hold_i (hold),
      .rate_i (rate),
      .tri_o  (tri_val),
      .valid_o(tri_valid)
   );

   // Depth is sampled here, so a depth change only affects ticks reaching this stage later.
   always_comb begin
      stage2_d       = stage2_q;
      stage2_d.valid = tri_valid;
      if (tri_valid) begin
         stage2_d.scaled = SAMPLE_W'((PROD_W'(tri_val) * PROD_W'(depth)) >> TRI_W);
      end
   end

   always_comb begin
      target   = clamp_delay(SUM_W'(BASE_VAL) + SUM_W'(stage2_q.scaled), MAX_VAL);
      valid3_d = stage2_q.valid;
      delay_d  = delay_q;
      if (stage2_q.valid) begin
`ifdef CHORUS_LFO_SMOOTH_EN
         delay_d = slew_toward(target, delay_q);
`else
         delay_d = target;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage2_q <= '0;
         valid3_q <= 1'b0;
         delay_q  <= BASE_VAL;
      end else begin
         stage2_q <= stage2_d;
         valid3_q <= valid3_d;
         delay_q  <= delay_d;
      end
   end

   assign delay      = delay_q;
   assign bufEnable  = valid3_q;
   assign delayValid = valid3_q;

endmodule

// File: tb/tb_chorus_lfo.sv
// Self-checking bench for chorus_lfo: a tick-level behavioural model is compared every cycle,
// plus literal expectations at known phase points.
module tb_chorus_lfo;

   localparam int BASE = 441;
   localparam int MAXD = 44099;

   logic        clk = 1'b0;
   logic        reset;
   logic        sampleTick;
   logic        hold;
   logic [15:0] rate;
   logic [15:0] depth;
   logic [15:0] delay;
   logic        bufEnable;
   logic        delayValid;

   int checks   = 0;
   int failures = 0;

   chorus_lfo dut (
      .clk       (clk),
      .reset     (reset),
      .sampleTick(sampleTick),
      .hold      (hold),
      .rate      (rate),
      .depth     (depth),
      .delay     (delay),
      .bufEnable (bufEnable),
      .delayValid(delayValid)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: each tick becomes a queued entry that matures two edges after it is sampled.
   typedef struct {
      int     due;
      longint triVal;
      longint scaled;
   } entry_t;

   entry_t pq[$];
   int     edgeCnt    = 0;
   int     mPhase     = 0;
   int     mDelay     = BASE;
   int     mPulse     = 0;
   bit     modelReady = 1'b0;

   always @(posedge clk) begin
      entry_t e;
      longint t;
      edgeCnt++;
      if (reset) begin
         pq.delete();
         mPhase     = 0;
         mDelay     = BASE;
         mPulse     = 0;
         modelReady = 1'b1;
      end else begin
         foreach (pq[i]) begin
            if (pq[i].due == edgeCnt + 1) begin
               pq[i].scaled = (pq[i].triVal * longint'(depth)) / 32768;
            end
         end
         if (sampleTick) begin
            if (!hold) begin
               mPhase = (mPhase + int'(rate)) % 16777216;
            end
            e.due    = edgeCnt + 2;
            e.triVal = (mPhase >= 'h800000) ? longint'((16777215 - mPhase) / 256) : longint'(mPhase / 256);
            e.scaled = 0;
            pq.push_back(e);
         end
         mPulse = 0;
         if (pq.size() > 0 && pq[0].due == edgeCnt) begin
            e = pq.pop_front();
            t = BASE + e.scaled;
            if (t > MAXD) t = MAXD;
`ifdef CHORUS_LFO_SMOOTH_EN
            if (t > mDelay) mDelay = mDelay + 1;
            else if (t < mDelay) mDelay = mDelay - 1;
`else
            mDelay = int'(t);
`endif
            mPulse = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (modelReady) begin
         checkOutput("modelDelay", int'(delay), mDelay);
         checkOutput("modelBufEnable", int'(bufEnable), mPulse);
         checkOutput("modelDelayValid", int'(delayValid), mPulse);
      end
   end

   // One spaced tick: pulse expected on the third negedge after the tick is driven.
   task automatic applyStimulus(input bit doCheck, input int expDelay);
      sampleTick = 1'b1;
      @(negedge clk);
      sampleTick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (doCheck) begin
         checkOutput("tickPulse", int'(bufEnable), 1);
         checkOutput("tickDelay", int'(delay), expDelay);
      end
      @(negedge clk);
   endtask

   task automatic doReset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int e;
      reset      = 1'b1;
      sampleTick = 1'b0;
      hold       = 1'b0;
      rate       = 16'h0;
      depth      = 16'h0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("resetDelay", int'(delay), 441);
      checkOutput("resetBufEnable", int'(bufEnable), 0);
      checkOutput("resetDelayValid", int'(delayValid), 0);

      $display("[TB] zero depth");
      rate  = 16'h8000;
      depth = 16'h0000;
      for (int i = 1; i <= 600; i++) applyStimulus(i == 1 || i == 600, 441);

`ifndef CHORUS_LFO_SMOOTH_EN
      $display("[TB] triangle sweep");
      doReset();
      depth = 16'h8000;
      for (int i = 1; i <= 512; i++) begin
         case (i)
            128:     e = 16825;
            256:     e = 33208;
            384:     e = 16824;
            default: e = 441;
         endcase
         applyStimulus(i == 128 || i == 256 || i == 384 || i == 512, e);
      end

      $display("[TB] clamp");
      doReset();
      depth = 16'hFFFF;
      for (int i = 1; i <= 256; i++) applyStimulus(i == 256, 44099);

      $display("[TB] hold and back-to-back");
      doReset();
      depth = 16'h8000;
      for (int i = 1; i <= 100; i++) applyStimulus(i == 100, 13241);
      hold = 1'b1;
      for (int j = 0; j < 8; j++) begin
         if (j >= 3) begin
            checkOutput("burstPulse", int'(bufEnable), 1);
            checkOutput("burstDelay", int'(delay), 13241);
         end
         sampleTick = (j < 5);
         @(negedge clk);
      end
      for (int j = 0; j < 11; j++) begin
         if (j == 3 || j == 4) begin
            checkOutput("preResetPulse", int'(bufEnable), 1);
            checkOutput("preResetDelay", int'(delay), 13241);
         end
         if (j >= 5) begin
            checkOutput("squashedPulse", int'(delayValid), 0);
            checkOutput("squashedDelay", int'(delay), 441);
         end
         sampleTick = (j < 5);
         reset      = (j == 4 || j == 5);
         @(negedge clk);
      end
      hold = 1'b0;
`else
      $display("[TB] smooth step");
      doReset();
      depth = 16'h0000;
      for (int i = 1; i <= 256; i++) applyStimulus(i == 256, 441);
      hold  = 1'b1;
      depth = 16'hFFFF;
      for (int j = 0; j < 43703; j++) begin
         if (j == 3 || j == 4 || j == 12 || j == 1003) begin
            checkOutput("slewPulse", int'(bufEnable), 1);
            checkOutput("slewDelay", int'(delay), 441 + j - 2);
         end
         sampleTick = (j < 43700);
         @(negedge clk);
      end
      checkOutput("slewFinal", int'(delay), 44099);
      checkOutput("slewIdle", int'(bufEnable), 0);
      hold = 1'b0;
`endif

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
